// File: rtl/rc_pulse_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : rc_pulse_decoder_if
// Description : Signal bundle for the servo-style PWM receiver. It carries the
//               raw pulse input and the decoded width/status outputs.
//               The slave side is the decoder. The master side is whoever
//               drives the pulse line and consumes the result.
// Revision    : 1.0 - initial release
// ============================================================================
interface rc_pulse_decoder_if;
    logic       pwm_in;
    logic [7:0] width;
    logic       valid;
    logic       new_sample;
    logic       pulse_err;

    modport master (
        output pwm_in,
        input  width,
        input  valid,
        input  new_sample,
        input  pulse_err
    );

    modport slave (
        input  pwm_in,
        output width,
        output valid,
        output new_sample,
        output pulse_err
    );
endinterface
`default_nettype wire

// File: rtl/rc_pulse_decoder.sv
`default_nettype none
// ============================================================================
// Module      : rc_pulse_decoder
// Description : Servo-style PWM receiver. It measures the high time of a
//               1 ms - 2 ms pulse train on the 255 kHz tick clock and recovers
//               the 8-bit width code (0 = 1 ms, 255 = 2 ms). It flags
//               out-of-range pulses and drops valid after a silence timeout.
//               Optional macro RC_DECODER_FAILSAFE_EN forces width to neutral
//               (127) when the timeout fires.
// Revision    : 1.0 - initial release
// ============================================================================
module rc_pulse_decoder #(
    parameter int OFFSET_TICKS  = 255,
    parameter int MIN_TICKS     = 128,
    parameter int MAX_TICKS     = 765,
    parameter int TIMEOUT_TICKS = 6375
) (
    input  wire logic        clk_255kHz,
    input  wire logic        reset,
    rc_pulse_decoder_if.slave bus
);

    localparam logic [9:0]  c_offset       = 10'(OFFSET_TICKS);
    localparam logic [9:0]  c_offset_top   = 10'(OFFSET_TICKS + 255);
    localparam logic [9:0]  c_min          = 10'(MIN_TICKS);
    localparam logic [9:0]  c_max          = 10'(MAX_TICKS);
    localparam logic [12:0] c_timeout_last = 13'(TIMEOUT_TICKS - 1);
    localparam logic [9:0]  c_high_sat     = 10'h3FF;
    localparam logic [12:0] c_per_sat      = 13'h1FFF;
    localparam logic [7:0]  c_neutral      = 8'd127;

    typedef enum logic [1:0] {
        ARM       = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_pwm_meta;
    logic        r_pwm_s;
    logic        r_pwm_q;
    logic [9:0]  r_high_cnt;
    logic [12:0] r_per_cnt;
    logic [7:0]  r_width;
    logic        r_valid;
    logic        r_new_sample;
    logic        r_pulse_err;

    logic        w_rise;
    logic        w_fall;
    logic        w_load;
    logic        w_accept;
    logic        w_reject;
    logic        w_timeout;
    logic [7:0]  w_code;

    assign w_rise = r_pwm_s & ~r_pwm_q;
    assign w_fall = ~r_pwm_s & r_pwm_q;

    // The low 8 bits of (high_cnt - offset) are all we need, so subtract in 8 bits.
    assign w_code = (r_high_cnt < c_offset)     ? 8'd0   :
                    (r_high_cnt > c_offset_top) ? 8'd255 :
                    (r_high_cnt[7:0] - c_offset[7:0]);

    // An accepted fall in the timeout cycle takes priority, so valid stays up.
    assign w_timeout = (r_per_cnt == c_timeout_last) && !w_accept;

    // Synchronise the asynchronous pulse line. These flops are not reset on
    // purpose: they keep tracking the line during reset. That way a pulse that
    // is still high at release is seen as high and is not measured.
    always_ff @(posedge clk_255kHz) begin
        r_pwm_meta <= bus.pwm_in;
        r_pwm_s    <= r_pwm_meta;
        r_pwm_q    <= r_pwm_s;
    end

    // State register for the measurement FSM.
    always_ff @(posedge clk_255kHz) begin
        if (reset) begin
            r_state <= ARM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and per-cycle load/accept/reject decisions.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        case (r_state)
            ARM: begin
                if (!r_pwm_s) begin
                    w_state_next = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (w_rise) begin
                    w_load       = 1'b1;
                    w_state_next = MEASURE;
                end
            end
            MEASURE: begin
                if (w_fall) begin
                    w_state_next = WAIT_RISE;
                    if ((r_high_cnt >= c_min) && (r_high_cnt <= c_max)) begin
                        w_accept = 1'b1;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ARM;
            end
        endcase
    end

    // Counters, decoded width, validity and one-cycle strobes.
    always_ff @(posedge clk_255kHz) begin
        if (reset) begin
            r_high_cnt   <= 10'd0;
            r_per_cnt    <= 13'd0;
            r_width      <= c_neutral;
            r_valid      <= 1'b0;
            r_new_sample <= 1'b0;
            r_pulse_err  <= 1'b0;
        end else begin
            if (w_load) begin
                r_high_cnt <= 10'd1;
            end else if ((r_state == MEASURE) && r_pwm_s && (r_high_cnt != c_high_sat)) begin
                r_high_cnt <= r_high_cnt + 10'd1;
            end

            if (w_accept) begin
                r_per_cnt <= 13'd0;
            end else if (r_per_cnt != c_per_sat) begin
                r_per_cnt <= r_per_cnt + 13'd1;
            end

            r_new_sample <= w_accept;
            r_pulse_err  <= w_reject;

            if (w_accept) begin
                r_width <= w_code;
                r_valid <= 1'b1;
            end else if (w_timeout) begin
                r_valid <= 1'b0;
`ifdef RC_DECODER_FAILSAFE_EN
                r_width <= c_neutral;
`endif
            end
        end
    end

    assign bus.width      = r_width;
    assign bus.valid      = r_valid;
    assign bus.new_sample = r_new_sample;
    assign bus.pulse_err  = r_pulse_err;

endmodule
`default_nettype wire

// File: tb/tb_rc_pulse_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_rc_pulse_decoder
// Description : Self-checking bench for rc_pulse_decoder. Pulses are driven on
//               the falling clock edge. The expected outcome of each pulse is
//               queued at its fall and compared when the decoder strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rc_pulse_decoder;

    localparam int c_min_ticks = 128;
    localparam int c_max_ticks = 765;
    localparam int c_offset    = 255;
    localparam int c_timeout   = 6375;

    logic clk_255kHz = 1'b0;
    logic reset      = 1'b1;
    int   cyc        = 0;

    rc_pulse_decoder_if bus();

    rc_pulse_decoder dut (
        .clk_255kHz (clk_255kHz),
        .reset      (reset),
        .bus        (bus.slave)
    );

    always #1961 clk_255kHz = ~clk_255kHz;

    always @(posedge clk_255kHz) cyc <= cyc + 1;

    typedef struct {
        logic       acc;
        logic [7:0] w;
        int         fall_cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_checks    = 0;
    int         n_pass      = 0;
    int         last_ns_cyc = 0;
    logic [7:0] model_width = 8'd127;
    int         loop_w[3]   = '{0, 64, 255};

    task automatic check(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    endtask

    // Record the expected outcome of a pulse of n_high ticks that ends now.
    task automatic push_expect(input int n_high);
        exp_t e;
        e.acc = (n_high >= c_min_ticks) && (n_high <= c_max_ticks);
        if (e.acc) begin
            if (n_high < c_offset)            model_width = 8'd0;
            else if (n_high > c_offset + 255) model_width = 8'd255;
            else                              model_width = 8'(n_high - c_offset);
        end
        e.w        = model_width;
        e.fall_cyc = cyc;
        sb.push_back(e);
    endtask

    // Drive one pulse (called on a falling edge): n_high sampled-high ticks, then n_low.
    task automatic pulse(input int n_high, input int n_low);
        bus.pwm_in = 1'b1;
        repeat (n_high) @(negedge clk_255kHz);
        bus.pwm_in = 1'b0;
        push_expect(n_high);
        repeat (n_low) @(negedge clk_255kHz);
    endtask

    // Compare every strobe against the oldest queued expectation.
    always @(negedge clk_255kHz) begin
        if (bus.new_sample || bus.pulse_err) begin
            check("sb_nonempty", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("strobe_accept", int'(bus.new_sample), int'(mon_e.acc));
                check("strobe_reject", int'(bus.pulse_err), int'(!mon_e.acc));
                check("strobe_width", int'(bus.width), int'(mon_e.w));
                check("strobe_latency", cyc - mon_e.fall_cyc, 3);
                if (mon_e.acc) check("strobe_valid", int'(bus.valid), 1);
            end
            if (bus.new_sample) last_ns_cyc = cyc;
        end
    end

    initial begin
        int drop_cyc;
        bus.pwm_in = 1'b0;
        reset      = 1'b1;
        repeat (4) @(negedge clk_255kHz);
        check("rst_width", int'(bus.width), 127);
        check("rst_valid", int'(bus.valid), 0);
        check("rst_new_sample", int'(bus.new_sample), 0);
        check("rst_pulse_err", int'(bus.pulse_err), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk_255kHz);

        // Steady 382/4718 train decodes to neutral.
        for (int i = 0; i < 3; i++) begin
            pulse(382, 4718);
            check("period_valid", int'(bus.valid), 1);
            check("period_width", int'(bus.width), 127);
        end

        // Clamping and acceptance boundaries.
        pulse(200, 1000);
        pulse(600, 1000);
        check("p600_valid", int'(bus.valid), 1);
        check("p600_width", int'(bus.width), 255);
        pulse(128, 600);
        pulse(765, 600);
        pulse(127, 600);
        pulse(766, 600);

        // Rejections leave a neutral width untouched.
        pulse(382, 300);
        pulse(100, 300);
        pulse(800, 300);
        check("reject_width", int'(bus.width), 127);

        // Stuck-high line: no strobe while high, valid times out.
        bus.pwm_in = 1'b1;
        repeat (10000) @(negedge clk_255kHz);
        check("stuck_valid", int'(bus.valid), 0);
        check("stuck_width", int'(bus.width), 127);
        bus.pwm_in = 1'b0;
        push_expect(10000);
        repeat (300) @(negedge clk_255kHz);

        // Silence after width 40: valid drops exactly c_timeout cycles later.
        pulse(295, 5);
        check("pre_timeout_width", int'(bus.width), 40);
        for (int i = 0; i < 7000 && bus.valid; i++) @(negedge clk_255kHz);
        drop_cyc = cyc;
        check("timeout_valid", int'(bus.valid), 0);
        check("timeout_cycles", drop_cyc - last_ns_cyc, c_timeout);
`ifdef RC_DECODER_FAILSAFE_EN
        model_width = 8'd127;
`endif
        check("timeout_width", int'(bus.width), int'(model_width));
        repeat (50) @(negedge clk_255kHz);

        // Reset in the middle of a pulse, line still high at release.
        bus.pwm_in = 1'b1;
        repeat (100) @(negedge clk_255kHz);
        reset = 1'b1;
        repeat (3) @(negedge clk_255kHz);
        check("midrst_width", int'(bus.width), 127);
        check("midrst_valid", int'(bus.valid), 0);
        reset = 1'b0;
        model_width = 8'd127;
        repeat (150) @(negedge clk_255kHz);
        bus.pwm_in = 1'b0;
        repeat (400) @(negedge clk_255kHz);
        check("midrst_no_strobe", sb.size(), 0);
        pulse(382, 1000);
        check("midrst_next_width", int'(bus.width), 127);

        // Generator-style loopback codes.
        foreach (loop_w[i]) begin
            pulse(c_offset + loop_w[i], 1000);
            check("loop_width_tol",
                  int'((int'(bus.width) - loop_w[i] <= 1) && (loop_w[i] - int'(bus.width) <= 1)), 1);
            check("loop_valid", int'(bus.valid), 1);
        end

        repeat (10) @(negedge clk_255kHz);
        check("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
